matrix_stream_loader: RTL and testbench

Parametrised, single-clock successor of the two-matrix Ethernet loader. It deserialises a narrow beat stream into ELEM_W-bit elements and assembles them into vectors of a runtime-selected length. It emits one write per completed vector to downstream dual-port storage, for NUM_MAT matrices in sequence. New over the previous loader: runtime dimension with zero padding, generic beat/element widths and matrix count, a gap timeout with error reporting, and automatic re-arm for back-to-back transfers.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/element_deserializer.sv | 57 +++++
 rtl/matrix_stream_loader.sv | 178 +++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream loader.
// Default-configuration derived widths live here for reuse by neighbouring blocks.
package matrix_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam int ELEM_W_DEF  = 8;
    localparam int IN_W_DEF    = 2;
    localparam int MAX_DIM_DEF = 32;

    localparam int BEATS  = ELEM_W_DEF / IN_W_DEF;
    localparam int DIM_W  = $clog2(MAX_DIM_DEF + 1);
    localparam int ADDR_W = $clog2(MAX_DIM_DEF);

    // Element 0 occupies the most significant slot of a packed vector.
    function automatic int slot_lo(input int idx, input int max_dim, input int elem_w);
        return (max_dim - 1 - idx) * elem_w;
    endfunction

endpackage

// File: rtl/element_deserializer.sv
// Collects IN_W-bit beats, most significant first, into ELEM_W-bit elements.
// elem_valid_o is combinational on the beat that completes an element.
module element_deserializer #(
    parameter int IN_W   = 2,
    parameter int ELEM_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              beat_valid_i,
    input  logic [IN_W-1:0]   beat_data_i,
    output logic              elem_valid_o,
    output logic [ELEM_W-1:0] elem_data_o
);
    localparam int NB = ELEM_W / IN_W;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [ELEM_W-1:0] shift_q, shift_d, shift_nxt;
    logic [CW-1:0]     cnt_q, cnt_d;

    if (ELEM_W > IN_W) begin : g_shift
        assign shift_nxt = {shift_q[ELEM_W-IN_W-1:0], beat_data_i};
    end else begin : g_single
        assign shift_nxt = beat_data_i;
    end

    assign elem_data_o = shift_nxt;

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        elem_valid_o = 1'b0;
        if (clr_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (beat_valid_i) begin
            shift_d = shift_nxt;
            if (cnt_q == CW'(NB - 1)) begin
                elem_valid_o = 1'b1;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_stream_loader.sv
// Deserialises a beat stream into runtime-length vectors and writes NUM_MAT matrices
// to dual-port storage, with gap timeout, config error reporting and auto re-arm.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter  int ELEM_W      = ELEM_W_DEF,
    parameter  int IN_W        = IN_W_DEF,
    parameter  int MAX_DIM     = MAX_DIM_DEF,
    parameter  int NUM_MAT     = 2,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int DW          = $clog2(MAX_DIM + 1),
    localparam int AW          = $clog2(MAX_DIM),
    localparam int MW          = $clog2(NUM_MAT),
    localparam int VW          = MAX_DIM * ELEM_W
) (
    input  logic            eth_refclk,
    input  logic            rst,
    input  logic [DW-1:0]   cfg_dim,
    input  logic            axiiv,
    input  logic [IN_W-1:0] axiid,
    output logic            wr_valid,
    output logic [MW-1:0]   wr_mat,
    output logic [AW-1:0]   wr_addr,
    output logic [VW-1:0]   wr_data,
    output logic            busy,
    output logic            complete,
    output logic            err
);
    localparam int GW = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [DW-1:0]     dim_q, dim_d, dim_eff;
    logic [AW-1:0]     elem_q, elem_d, vec_q, vec_d;
    logic [MW-1:0]     mat_q, mat_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [VW-1:0]     buf_q, buf_d, vec_full;
    logic              wr_valid_q, wr_valid_d, complete_q, complete_d, err_q, err_d;
    logic [MW-1:0]     wr_mat_q, wr_mat_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [VW-1:0]     wr_data_q, wr_data_d;
    logic              cfg_ok, take, timeout, elem_v;
    logic [ELEM_W-1:0] elem_data;

    // In IDLE the first beat must use the live cfg_dim since dim_q is not yet latched.
    assign cfg_ok  = (cfg_dim != '0) && (cfg_dim <= DW'(MAX_DIM));
    assign take    = axiiv && ((state_q == LOAD) || cfg_ok);
    assign dim_eff = (state_q == IDLE) ? cfg_dim : dim_q;
    assign timeout = (state_q == LOAD) && !axiiv && (gap_q == GW'(TIMEOUT_CYC - 1));

    element_deserializer #(
        .IN_W   (IN_W),
        .ELEM_W (ELEM_W)
    ) u_deser (
        .clk          (eth_refclk),
        .rst          (rst),
        .clr_i        (timeout),
        .beat_valid_i (take),
        .beat_data_i  (axiid),
        .elem_valid_o (elem_v),
        .elem_data_o  (elem_data)
    );

    always_comb begin
        state_d    = state_q;
        dim_d      = dim_q;
        elem_d     = elem_q;
        vec_d      = vec_q;
        mat_d      = mat_q;
        gap_d      = gap_q;
        buf_d      = buf_q;
        wr_valid_d = 1'b0;
        complete_d = 1'b0;
        err_d      = 1'b0;
        wr_mat_d   = wr_mat_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        vec_full   = buf_q;

        case (state_q)
            IDLE: begin
                if (axiiv) begin
                    if (cfg_ok) begin
                        dim_d   = cfg_dim;
                        gap_d   = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (axiiv) begin
                    gap_d = '0;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    gap_d   = '0;
                    buf_d   = '0;
                    elem_d  = '0;
                    vec_d   = '0;
                    mat_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Buffer is cleared after every write, so slots at or beyond dim stay zero.
        if (elem_v) begin
            vec_full[slot_lo(int'(elem_q), MAX_DIM, ELEM_W) +: ELEM_W] = elem_data;
            buf_d = vec_full;
            if (DW'(elem_q) == dim_eff - DW'(1)) begin
                wr_valid_d = 1'b1;
                wr_mat_d   = mat_q;
                wr_addr_d  = vec_q;
                wr_data_d  = vec_full;
                buf_d      = '0;
                elem_d     = '0;
                if (DW'(vec_q) == dim_eff - DW'(1)) begin
                    vec_d = '0;
                    if (mat_q == MW'(NUM_MAT - 1)) begin
                        mat_d      = '0;
                        complete_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        mat_d = mat_q + MW'(1);
                    end
                end else begin
                    vec_d = vec_q + AW'(1);
                end
            end else begin
                elem_d = elem_q + AW'(1);
            end
        end
    end

    always_ff @(posedge eth_refclk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dim_q      <= '0;
            elem_q     <= '0;
            vec_q      <= '0;
            mat_q      <= '0;
            gap_q      <= '0;
            buf_q      <= '0;
            wr_valid_q <= 1'b0;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
            wr_mat_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            dim_q      <= dim_d;
            elem_q     <= elem_d;
            vec_q      <= vec_d;
            mat_q      <= mat_d;
            gap_q      <= gap_d;
            buf_q      <= buf_d;
            wr_valid_q <= wr_valid_d;
            complete_q <= complete_d;
            err_q      <= err_d;
            wr_mat_q   <= wr_mat_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_mat   = wr_mat_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign complete = complete_q;
    assign err      = err_q;
    assign busy     = (state_q == LOAD);

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: directed transfers push expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_matrix_stream_loader;
    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 32;
    localparam int NUM_MAT = 2;
    localparam int TO      = 1024;
    localparam int VW      = MAX_DIM * ELEM_W;

    typedef struct {
        logic [0:0]    mat;
        logic [4:0]    addr;
        logic [VW-1:0] data;
        logic          cpl;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    cfg_dim = '0;
    logic          axiiv = 1'b0;
    logic [1:0]    axiid = '0;
    logic          wr_valid, busy, complete, err;
    logic [0:0]    wr_mat;
    logic [4:0]    wr_addr;
    logic [VW-1:0] wr_data;

    wr_t           exp_q[$];
    logic [VW-1:0] log_q[$];
    wr_t           e_m;
    logic [VW-1:0] w;
    int checks = 0, errors = 0;
    int wr_seen = 0, cpl_seen = 0, err_seen = 0;
    int mode = 0;

    matrix_stream_loader #(
        .ELEM_W(ELEM_W), .IN_W(2), .MAX_DIM(MAX_DIM), .NUM_MAT(NUM_MAT), .TIMEOUT_CYC(TO)
    ) dut (
        .eth_refclk(clk), .rst(rst), .cfg_dim(cfg_dim), .axiiv(axiiv), .axiid(axiid),
        .wr_valid(wr_valid), .wr_mat(wr_mat), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .complete(complete), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk_n(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic chk_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] val(input int k);
        return (mode == 0) ? 8'(k % 256) : 8'(161 + k);
    endfunction

    always @(negedge clk) begin
        if (wr_valid) begin
            wr_seen++;
            if (complete) cpl_seen++;
            log_q.push_back(wr_data);
            if (exp_q.size() == 0) begin
                chk_n("unexpected_write", int'(wr_valid), 0);
            end else begin
                e_m = exp_q.pop_front();
                chk_n("wr_mat", int'(wr_mat), int'(e_m.mat));
                chk_n("wr_addr", int'(wr_addr), int'(e_m.addr));
                chk_v("wr_data", wr_data, e_m.data);
                chk_n("complete", int'(complete), int'(e_m.cpl));
                if (complete) chk_n("busy_on_final", int'(busy), 0);
            end
        end else if (complete) begin
            chk_n("complete_without_write", int'(complete), 0);
        end
        if (err) err_seen++;
    end

    task automatic beat(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        axiiv = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected writes are pushed up front for every vector the stream completes.
    task automatic load(input int dim, input int nel, input bit gapped);
        int nvec;
        nvec = nel / dim;
        for (int j = 0; j < nvec; j++) begin
            wr_t e;
            e.mat  = 1'((j / dim) % NUM_MAT);
            e.addr = 5'(j % dim);
            e.data = '0;
            e.cpl  = (j == NUM_MAT * dim - 1);
            for (int s = 0; s < dim; s++)
                e.data[(MAX_DIM - 1 - s) * ELEM_W +: ELEM_W] = val(j * dim + s);
            exp_q.push_back(e);
        end
        cfg_dim = 6'(dim);
        for (int k = 0; k < nel; k++) begin
            logic [7:0] v;
            v = val(k);
            for (int b = 0; b < 4; b++) begin
                beat(v[7 - 2 * b -: 2]);
                if (k == 0 && b == 0) cfg_dim = '0;
                if (gapped) idle(1);
            end
        end
        axiiv = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        chk_n("scoreboard_drained", exp_q.size(), 0);
        idle(2);
    endtask

    task automatic clr_stats();
        wr_seen  = 0;
        cpl_seen = 0;
        err_seen = 0;
        log_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk_n({tag, "_wr_valid"}, int'(wr_valid), 0);
        chk_n({tag, "_busy"}, int'(busy), 0);
        chk_n({tag, "_complete"}, int'(complete), 0);
        chk_n({tag, "_err"}, int'(err), 0);
        chk_n({tag, "_wr_mat"}, int'(wr_mat), 0);
        chk_n({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk_v({tag, "_wr_data"}, wr_data, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded bound, got timeout want finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full-size transfer, two 32x32 matrices.
        clr_stats();
        mode = 0;
        load(32, 2048, 0);
        drain();
        chk_n("t1_writes", wr_seen, 64);
        chk_n("t1_completes", cpl_seen, 1);
        chk_n("t1_errs", err_seen, 0);
        w = (log_q.size() > 0) ? log_q[0] : '1;
        chk_n("t1_v0_slot0", int'(w[255:248]), 8'h00);
        chk_n("t1_v0_slot31", int'(w[7:0]), 8'h1F);

        // Padding with dim 3.
        clr_stats();
        mode = 1;
        load(3, 18, 0);
        drain();
        chk_n("t2_writes", wr_seen, 6);
        chk_n("t2_completes", cpl_seen, 1);
        w = (log_q.size() > 0) ? log_q[0] : '1;
        chk_n("t2_v0_head", int'(w[255:232]), 24'hA1A2A3);
        chk_v("t2_v0_pad", {24'h0, w[231:0]}, '0);

        // Same transfer with a gap on every other cycle.
        clr_stats();
        load(3, 18, 1);
        drain();
        chk_n("t3_writes", wr_seen, 6);
        chk_n("t3_completes", cpl_seen, 1);
        chk_n("t3_errs", err_seen, 0);

        // Timeout after one full vector plus one element.
        clr_stats();
        mode = 0;
        load(4, 5, 0);
        idle(TO - 1);
        chk_n("t4_busy_before_timeout", int'(busy), 1);
        chk_n("t4_no_err_before_timeout", err_seen, 0);
        idle(1);
        chk_n("t4_err_pulse", int'(err), 1);
        chk_n("t4_busy_after_timeout", int'(busy), 0);
        idle(1);
        chk_n("t4_err_one_cycle", int'(err), 0);
        chk_n("t4_writes", wr_seen, 1);
        chk_n("t4_completes", cpl_seen, 0);
        chk_n("t4_err_count", err_seen, 1);
        chk_n("t4_scoreboard_empty", exp_q.size(), 0);
        clr_stats();
        load(2, 8, 0);
        drain();
        chk_n("t4_restart_writes", wr_seen, 4);
        chk_n("t4_restart_completes", cpl_seen, 1);

        // Bad configurations are rejected beat by beat.
        clr_stats();
        cfg_dim = 6'd0;
        for (int i = 0; i < 8; i++) begin
            beat(2'b11);
            chk_n("t5_busy_low", int'(busy), 0);
        end
        cfg_dim = 6'd33;
        beat(2'b01);
        beat(2'b10);
        idle(2);
        chk_n("t5_err_count", err_seen, 10);
        chk_n("t5_writes", wr_seen, 0);
        chk_n("t5_busy_idle", int'(busy), 0);

        // Reset during matrix 1, then two transfers back to back.
        clr_stats();
        mode = 0;
        load(2, 5, 0);
        chk_n("t6_busy_mid", int'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk_outputs_zero("t6_async_reset");
        chk_n("t6_scoreboard_empty", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clr_stats();
        load(2, 8, 0);
        mode = 1;
        load(3, 18, 0);
        drain();
        chk_n("t6_writes", wr_seen, 10);
        chk_n("t6_completes", cpl_seen, 2);
        chk_n("t6_errs", err_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
